// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch bank controller: opcodes, FSM states
// and requester ids.
package sr_ctrl_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational from req.
// The priority pointer moves to the other requester whenever advance is high.
module sr_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_prio_b;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_prio_b ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After A is served, B holds priority, and the reverse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio_b <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      r_prio_b <= gnt[0];
    end
  end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Sequences SET/CLEAR/TOGGLE pulses onto a NOR SR latch bank shared by two
// requesters. Optional readback check: SR_LATCH_BANK_CTRL_VERIFY_EN.
module sr_latch_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_LATCH   = 8,
  parameter int IDX_W     = $clog2(N_LATCH),
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  input  logic [1:0]         a_op,
  input  logic [IDX_W-1:0]   a_idx,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [1:0]         b_op,
  input  logic [IDX_W-1:0]   b_idx,
  output logic               b_ready,
  input  logic [N_LATCH-1:0] q_in,
  output logic [N_LATCH-1:0] s_out,
  output logic [N_LATCH-1:0] r_out,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic               err,
  output logic [1:0]         dbg_state
);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [N_LATCH-1:0] r_s, r_r, w_s_nxt, w_r_nxt;
  logic               r_id, r_err;
  logic [1:0]         w_req, w_gnt;
  logic               w_idle, w_acc, w_sel_b;
  logic [1:0]         w_op;
  logic [IDX_W-1:0]   w_idx;
  logic [N_LATCH-1:0] w_oh;
  logic               w_in_range, w_active, w_do_set;

  assign w_idle = (r_state == IDLE);
  assign w_req  = {b_valid, a_valid} & {2{w_idle}};

  sr_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_acc),
    .gnt     (w_gnt)
  );

  // Handshake: a command transfers on a rising edge where x_valid && x_ready.
  // x_ready is combinational, only possible in IDLE, and never both at once;
  // requesters keep valid/op/idx stable until they see ready.
  assign a_ready = w_idle & a_valid & w_gnt[0];
  assign b_ready = w_idle & b_valid & w_gnt[1];
  assign w_acc   = a_ready | b_ready;
  assign w_sel_b = w_gnt[1];

  assign w_op       = w_sel_b ? b_op : a_op;
  assign w_idx      = w_sel_b ? b_idx : a_idx;
  assign w_in_range = 32'(w_idx) < 32'(N_LATCH);
  assign w_oh       = {{(N_LATCH-1){1'b0}}, 1'b1} << w_idx;
  assign w_active   = w_in_range && (w_op != OP_NOP);
  // TOGGLE is decided from the latch state seen at the accept edge.
  assign w_do_set   = (w_op == OP_SET) ||
                      ((w_op == OP_TGL) && !(|(q_in & w_oh)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = '0;
    w_r_nxt     = '0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_cnt_nxt = 4'd0;
          if (w_active) begin
            w_state_nxt = PULSE;
            w_s_nxt     = w_do_set ? w_oh : '0;
            w_r_nxt     = w_do_set ? '0 : w_oh;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      PULSE: begin
        if (r_cnt == 4'(PULSE_CYC - 1)) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
          w_s_nxt   = r_s;
          w_r_nxt   = r_r;
        end
      end
      GAP: begin
        if (r_cnt == 4'(GAP_CYC - 1)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SR_LATCH_BANK_CTRL_VERIFY_EN
  logic [N_LATCH-1:0] r_oh;
  logic               r_set, r_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_oh  <= '0;
      r_set <= 1'b0;
      r_act <= 1'b0;
    end else if (w_acc) begin
      r_oh  <= w_oh;
      r_set <= w_do_set;
      r_act <= w_active;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_s     <= '0;
      r_r     <= '0;
      r_id    <= REQ_A;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      if (w_acc) begin
        r_id <= w_sel_b ? REQ_B : REQ_A;
      end
      if (w_acc && (w_op != OP_NOP) && !w_in_range) begin
        r_err <= 1'b1;
      end
`ifdef SR_LATCH_BANK_CTRL_VERIFY_EN
      // Readback: the latch must now hold 1 after SET and 0 after CLEAR.
      if ((r_state == DONE) && r_act && (r_set != (|(q_in & r_oh)))) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

  assign s_out     = r_s;
  assign r_out     = r_r;
  assign busy      = !w_idle;
  assign done      = (r_state == DONE);
  assign done_id   = done & r_id;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Directed bench for sr_latch_bank_ctrl with a behavioural NOR latch bank
// feeding q_in; table-driven single-requester ops plus arbitration/reset cases.
module tb_sr_latch_bank_ctrl;
  import sr_ctrl_pkg::*;

  localparam int N  = 8;
  localparam int IW = 4;
  localparam int P  = 2;
  localparam int G  = 1;
`ifdef SR_LATCH_BANK_CTRL_VERIFY_EN
  localparam logic EXP_VERIFY_ERR = 1'b1;
`else
  localparam logic EXP_VERIFY_ERR = 1'b0;
`endif

  typedef struct {
    logic [1:0]    op;
    logic [IW-1:0] idx;
    logic [N-1:0]  exp_s;
    logic [N-1:0]  exp_r;
    int            lat;
    logic          exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0]    a_op = 2'b00, b_op = 2'b00;
  logic [IW-1:0] a_idx = '0, b_idx = '0;
  logic          a_ready, b_ready;
  logic [N-1:0]  q_in, s_out, r_out;
  logic          busy, done, done_id, err;
  logic [1:0]    dbg_state;
  logic [N-1:0]  q_model = '0;
  logic [N-1:0]  stuck_lo = '0;
  logic          mon_en = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  logic exp_q[$];
  logic pend_q[$];
  vec_t tbl[10];

  sr_latch_bank_ctrl #(.N_LATCH(N), .IDX_W(IW), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_op(a_op), .a_idx(a_idx), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_idx(b_idx), .b_ready(b_ready),
    .q_in(q_in), .s_out(s_out), .r_out(r_out),
    .busy(busy), .done(done), .done_id(done_id), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // NOR latch bank model; stuck_lo emulates a latch that will not set.
  always @(posedge clk) q_model <= (q_model | s_out) & ~r_out;
  assign q_in = q_model & ~stuck_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("s_and_r_zero", 32'(s_out & r_out), 32'd0);
      check("one_hot_drive", 32'($countones(s_out | r_out) <= 1), 32'd1);
      check("ready_exclusive", 32'(a_ready & b_ready), 32'd0);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic run_a(input vec_t v, input string tag);
    cyc();
    a_valid = 1'b1; a_op = v.op; a_idx = v.idx;
    settle();
    check({tag, "_a_ready"}, 32'(a_ready), 32'd1);
    check({tag, "_b_ready"}, 32'(b_ready), 32'd0);
    for (int c = 1; c <= v.lat; c++) begin
      cyc();
      a_valid = 1'b0;
      settle();
      check({tag, "_s_out"}, 32'(s_out), 32'((c <= P) ? v.exp_s : '0));
      check({tag, "_r_out"}, 32'(r_out), 32'((c <= P) ? v.exp_r : '0));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done"}, 32'(done), 32'(c == v.lat));
      if (c == v.lat) begin
        check({tag, "_done_id"}, 32'(done_id), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(v.exp_err));
      end
    end
  endtask

  // Grants are checked against exp_q, completions against pend_q.
  task automatic arb_run(input logic av, input logic bv, input string tag);
    int budget;
    budget = 80;
    a_op = OP_SET; a_idx = 4'd1;
    b_op = OP_CLR; b_idx = 4'd1;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && budget > 0) begin
      cyc();
      budget--;
      a_valid = av && (exp_q.size() != 0);
      b_valid = bv && (exp_q.size() != 0);
      settle();
      if (done) begin
        if (pend_q.size() == 0) check({tag, "_unexpected_done"}, 32'd1, 32'd0);
        else check({tag, "_done_id"}, 32'(done_id), 32'(pend_q.pop_front()));
      end
      if (a_ready || b_ready) begin
        if (exp_q.size() == 0) check({tag, "_unexpected_grant"}, 32'd1, 32'd0);
        else begin
          check({tag, "_grant_id"}, 32'(b_ready), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          pend_q.push_back(b_ready);
        end
      end
    end
    check({tag, "_timeout"}, 32'(budget > 0), 32'd1);
    exp_q.delete();
    pend_q.delete();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{OP_SET, 4'd3, 8'h08, 8'h00, P+G+1, 1'b0};
    tbl[1] = '{OP_SET, 4'd5, 8'h20, 8'h00, P+G+1, 1'b0};
    tbl[2] = '{OP_TGL, 4'd5, 8'h00, 8'h20, P+G+1, 1'b0};
    tbl[3] = '{OP_TGL, 4'd5, 8'h20, 8'h00, P+G+1, 1'b0};
    tbl[4] = '{OP_CLR, 4'd3, 8'h00, 8'h08, P+G+1, 1'b0};
    tbl[5] = '{OP_SET, 4'd7, 8'h80, 8'h00, P+G+1, 1'b0};
    tbl[6] = '{OP_SET, 4'd0, 8'h01, 8'h00, P+G+1, 1'b0};
    tbl[7] = '{OP_NOP, 4'd2, 8'h00, 8'h00, 1,     1'b0};
    tbl[8] = '{OP_SET, 4'd9, 8'h00, 8'h00, 1,     1'b1};
    tbl[9] = '{OP_CLR, 4'd1, 8'h00, 8'h02, P+G+1, 1'b1};

    // reset state
    do_reset();
    settle();
    mon_en = 1'b1;
    check("rst_s_out", 32'(s_out), 32'd0);
    check("rst_r_out", 32'(r_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_a_ready_novalid", 32'(a_ready), 32'd0);

    for (int i = 0; i < 10; i++) run_a(tbl[i], $sformatf("vec%0d", i));
    cyc();
    settle();
    check("err_sticky", 32'(err), 32'd1);

    // readback check against a latch that will not set
    do_reset();
    settle();
    check("err_cleared_by_rst", 32'(err), 32'd0);
    stuck_lo = 8'h04;
    run_a('{OP_SET, 4'd2, 8'h04, 8'h00, P+G+1, 1'b0}, "verify");
    cyc();
    settle();
    check("verify_err", 32'(err), 32'(EXP_VERIFY_ERR));
    stuck_lo = '0;

    // arbitration: alternate under contention, then B-first after a lone A
    do_reset();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    arb_run(1'b1, 1'b1, "arb_both");
    exp_q = '{1'b0};
    arb_run(1'b1, 1'b0, "arb_a_only");
    exp_q = '{1'b1, 1'b0};
    arb_run(1'b1, 1'b1, "arb_b_first");

    // reset in the middle of a pulse
    cyc();
    a_valid = 1'b1; a_op = OP_SET; a_idx = 4'd0;
    settle();
    check("midrst_a_ready", 32'(a_ready), 32'd1);
    cyc();
    a_valid = 1'b0; rst = 1'b1;
    settle();
    check("midrst_pulse_on", 32'(s_out), 32'h01);
    cyc();
    rst = 1'b0;
    settle();
    check("midrst_s_out", 32'(s_out), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      settle();
      check("midrst_no_done", 32'(done), 32'd0);
    end
    run_a('{OP_SET, 4'd0, 8'h01, 8'h00, P+G+1, 1'b0}, "after_rst");

    cyc();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
